// File: rtl/uart_cmd_ctrl.sv
// Command-frame controller: assembles SYNC/CMD/PTR/DHI/DLO/CKS frames from UART bytes,
// validates them and issues one register request to the I2C master over req/ack.
module uart_cmd_ctrl #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter logic [7:0]  CMD_WR         = 8'h01,
  parameter logic [7:0]  CMD_RD         = 8'h02
) (
  input  logic        clk_in,
  input  logic        n_rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        req_out,
  output logic [7:0]  cmd_out,
  output logic [7:0]  ptr_out,
  output logic [15:0] wdata_out,
  input  logic        ack_in,
  output logic        busy_out,
  output logic        frame_done,
  output logic        err_cksum,
  output logic        err_cmd,
  output logic        err_timeout,
  output logic        err_overrun
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  // Terminal check is made on the value the counter holds one cycle before it would
  // reach TIMEOUT_CYCLES-1, so the error pulse lands exactly on that cycle.
  localparam logic [CntW-1:0] CntTerm = CntW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_PTR, S_DHI, S_DLO, S_CKS, S_ISSUE
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      acc_q, acc_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      ptr_q, ptr_d;
  logic [7:0]      dhi_q, dhi_d;
  logic [7:0]      dlo_q, dlo_d;
  logic            req_q, req_d;
  logic            done_q, done_d;
  logic            cksum_q, cksum_d;
  logic            ecmd_q, ecmd_d;
  logic            tmo_q, tmo_d;
  logic            ovr_q, ovr_d;
  logic            in_frame;

  assign in_frame = (state_q == S_CMD) || (state_q == S_PTR) || (state_q == S_DHI) ||
                    (state_q == S_DLO) || (state_q == S_CKS);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    cmd_d   = cmd_q;
    ptr_d   = ptr_q;
    dhi_d   = dhi_q;
    dlo_d   = dlo_q;
    req_d   = req_q;
    done_d  = 1'b0;
    cksum_d = 1'b0;
    ecmd_d  = 1'b0;
    tmo_d   = 1'b0;
    ovr_d   = 1'b0;

    // A byte on the terminal cycle wins over the timeout.
    if (in_frame) begin
      if (rx_valid) begin
        cnt_d = '0;
      end else if (cnt_q == CntTerm) begin
        tmo_d   = 1'b1;
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d = S_CMD;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      S_CMD: begin
        if (rx_valid) begin
          cmd_d   = rx_data;
          acc_d   = acc_q ^ rx_data;
          state_d = S_PTR;
        end
      end
      S_PTR: begin
        if (rx_valid) begin
          ptr_d   = rx_data;
          acc_d   = acc_q ^ rx_data;
          state_d = S_DHI;
        end
      end
      S_DHI: begin
        if (rx_valid) begin
          dhi_d   = rx_data;
          acc_d   = acc_q ^ rx_data;
          state_d = S_DLO;
        end
      end
      S_DLO: begin
        if (rx_valid) begin
          dlo_d   = rx_data;
          acc_d   = acc_q ^ rx_data;
          state_d = S_CKS;
        end
      end
      S_CKS: begin
        if (rx_valid) begin
          if ((acc_q ^ rx_data) != 8'h00) begin
            cksum_d = 1'b1;
            state_d = S_IDLE;
          end else if ((cmd_q != CMD_WR) && (cmd_q != CMD_RD)) begin
            ecmd_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            req_d   = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        // Completion takes precedence; a byte coinciding with ack is simply dropped.
        if (ack_in) begin
          req_d   = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (rx_valid) begin
          ovr_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      cmd_q   <= '0;
      ptr_q   <= '0;
      dhi_q   <= '0;
      dlo_q   <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      cksum_q <= 1'b0;
      ecmd_q  <= 1'b0;
      tmo_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      cmd_q   <= cmd_d;
      ptr_q   <= ptr_d;
      dhi_q   <= dhi_d;
      dlo_q   <= dlo_d;
      req_q   <= req_d;
      done_q  <= done_d;
      cksum_q <= cksum_d;
      ecmd_q  <= ecmd_d;
      tmo_q   <= tmo_d;
      ovr_q   <= ovr_d;
    end
  end

  assign req_out     = req_q;
  assign cmd_out     = cmd_q;
  assign ptr_out     = ptr_q;
  assign wdata_out   = {dhi_q, dlo_q};
  assign busy_out    = (state_q != S_IDLE);
  assign frame_done  = done_q;
  assign err_cksum   = cksum_q;
  assign err_cmd     = ecmd_q;
  assign err_timeout = tmo_q;
  assign err_overrun = ovr_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: expected events queued as frames are sent,
// popped and compared when the DUT raises req_out or a status pulse.
module tb_uart_cmd_ctrl;

  localparam int unsigned Tmo = 100;

  logic        clk_in = 1'b0;
  logic        n_rst = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        ack_in = 1'b0;
  logic        req_out, busy_out, frame_done;
  logic        err_cksum, err_cmd, err_timeout, err_overrun;
  logic [7:0]  cmd_out, ptr_out;
  logic [15:0] wdata_out;

  uart_cmd_ctrl #(
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (Tmo),
    .CMD_WR         (8'h01),
    .CMD_RD         (8'h02)
  ) u_dut (
    .clk_in      (clk_in),
    .n_rst       (n_rst),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .req_out     (req_out),
    .cmd_out     (cmd_out),
    .ptr_out     (ptr_out),
    .wdata_out   (wdata_out),
    .ack_in      (ack_in),
    .busy_out    (busy_out),
    .frame_done  (frame_done),
    .err_cksum   (err_cksum),
    .err_cmd     (err_cmd),
    .err_timeout (err_timeout),
    .err_overrun (err_overrun)
  );

  always #5 clk_in = ~clk_in;

  typedef enum int {EvNone, EvReq, EvDone, EvCksum, EvCmd, EvTimeout, EvOverrun} ev_e;
  typedef struct {
    ev_e         kind;
    logic [7:0]  cmd;
    logic [7:0]  ptr;
    logic [15:0] wdata;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic req_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push_ev(input ev_e k, input logic [7:0] c, input logic [7:0] p,
                         input logic [15:0] w);
    exp_t e;
    e.kind  = k;
    e.cmd   = c;
    e.ptr   = p;
    e.wdata = w;
    sb_q.push_back(e);
  endtask

  // Reference model of frame validation.
  task automatic expect_frame(input logic [7:0] c, input logic [7:0] p, input logic [7:0] dh,
                              input logic [7:0] dl, input logic [7:0] k);
    if ((c ^ p ^ dh ^ dl ^ k) != 8'h00)       push_ev(EvCksum, 8'h00, 8'h00, 16'h0000);
    else if ((c != 8'h01) && (c != 8'h02))    push_ev(EvCmd, 8'h00, 8'h00, 16'h0000);
    else                                      push_ev(EvReq, c, p, {dh, dl});
  endtask

  task automatic sb_observe(input ev_e kind);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq("sb_unexpected", kind, EvNone);
    end else begin
      e = sb_q.pop_front();
      check_eq("sb_kind", kind, e.kind);
      if (kind == EvReq && e.kind == EvReq) begin
        check_eq("sb_cmd", {24'h0, cmd_out}, {24'h0, e.cmd});
        check_eq("sb_ptr", {24'h0, ptr_out}, {24'h0, e.ptr});
        check_eq("sb_wdata", {16'h0, wdata_out}, {16'h0, e.wdata});
      end
    end
  endtask

  always @(negedge clk_in) begin
    int npulse;
    if (!n_rst) begin
      req_prev = 1'b0;
    end else begin
      npulse = int'(frame_done) + int'(err_cksum) + int'(err_cmd) + int'(err_timeout) +
               int'(err_overrun);
      if (npulse > 1) check_eq("pulse_exclusive", npulse, 1);
      if (req_out && !req_prev) sb_observe(EvReq);
      if (frame_done)  sb_observe(EvDone);
      if (err_cksum)   sb_observe(EvCksum);
      if (err_cmd)     sb_observe(EvCmd);
      if (err_timeout) sb_observe(EvTimeout);
      if (err_overrun) sb_observe(EvOverrun);
      req_prev = req_out;
    end
  end

  task automatic send(input logic [7:0] b, input int idle);
    repeat (idle) @(posedge clk_in);
    @(posedge clk_in);
    #1 rx_valid = 1'b1;
    rx_data = b;
    @(posedge clk_in);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] p, input logic [7:0] dh,
                            input logic [7:0] dl, input logic [7:0] k, input bit skip_sync);
    expect_frame(c, p, dh, dl, k);
    if (!skip_sync) send(8'hA5, 0);
    send(c, 0);
    send(p, 0);
    send(dh, 0);
    send(dl, 0);
    send(k, 0);
  endtask

  // Acks after n cycles; b2b places a SYNC byte in the frame_done cycle.
  task automatic do_ack(input int n, input bit b2b);
    push_ev(EvDone, 8'h00, 8'h00, 16'h0000);
    repeat (n) @(posedge clk_in);
    #1 check_eq("req_held", {31'h0, req_out}, 32'd1);
    ack_in = 1'b1;
    @(posedge clk_in);
    #1 ack_in = 1'b0;
    check_eq("ack_req_low", {31'h0, req_out}, 32'd0);
    check_eq("ack_done", {31'h0, frame_done}, 32'd1);
    check_eq("ack_idle", {31'h0, busy_out}, 32'd0);
    if (b2b) begin
      rx_valid = 1'b1;
      rx_data  = 8'hA5;
      @(posedge clk_in);
      #1 rx_valid = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    bit seen;
    repeat (3) @(posedge clk_in);
    #1;
    check_eq("rst_outs", {req_out, busy_out, frame_done, err_cksum, err_cmd, err_timeout,
                          err_overrun}, 32'd0);
    check_eq("rst_fields", {cmd_out, ptr_out, wdata_out}, 32'd0);
    @(negedge clk_in);
    n_rst = 1'b1;

    // Valid write, then read frame starting in the frame_done cycle.
    send_frame(8'h01, 8'h00, 8'h84, 8'h83, 8'h06, 1'b0);
    check_eq("wr_req", {31'h0, req_out}, 32'd1);
    check_eq("wr_wdata", {16'h0, wdata_out}, 32'h8483);
    do_ack(5, 1'b1);
    send_frame(8'h02, 8'h48, 8'h00, 8'h00, 8'h4A, 1'b1);
    check_eq("rd_req", {31'h0, req_out}, 32'd1);
    do_ack(3, 1'b0);

    // Checksum error, then a normal frame.
    send_frame(8'h02, 8'h01, 8'h00, 8'h00, 8'hFF, 1'b0);
    check_eq("cks_no_req", {31'h0, req_out}, 32'd0);
    send_frame(8'h01, 8'h01, 8'h12, 8'h34, 8'h26, 1'b0);
    do_ack(2, 1'b0);

    // Unknown command with correct checksum.
    send_frame(8'h07, 8'h00, 8'h00, 8'h00, 8'h07, 1'b0);
    check_eq("cmd_no_req", {31'h0, req_out}, 32'd0);

    // Timeout: error exactly Tmo-1 cycles after the last accepted byte.
    push_ev(EvTimeout, 8'h00, 8'h00, 16'h0000);
    send(8'hA5, 0);
    send(8'h01, 0);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 2 * Tmo) begin
      @(posedge clk_in);
      n++;
      #1 seen = err_timeout;
    end
    check_eq("tmo_seen", {31'h0, seen}, 32'd1);
    check_eq("tmo_cycles", n, Tmo - 1);
    check_eq("tmo_idle", {31'h0, busy_out}, 32'd0);

    // Byte landing on the terminal cycle is accepted.
    expect_frame(8'h01, 8'h00, 8'h84, 8'h83, 8'h06);
    send(8'hA5, 0);
    send(8'h01, 0);
    send(8'h00, Tmo - 3);
    send(8'h84, 0);
    send(8'h83, 0);
    send(8'h06, 0);
    check_eq("term_req", {31'h0, req_out}, 32'd1);
    do_ack(1, 1'b0);

    // Overrun while request pending.
    send_frame(8'h02, 8'h01, 8'h00, 8'h00, 8'h03, 1'b0);
    push_ev(EvOverrun, 8'h00, 8'h00, 16'h0000);
    send(8'h55, 0);
    check_eq("ovr_req", {31'h0, req_out}, 32'd1);
    check_eq("ovr_fields", {8'h0, cmd_out, ptr_out, 8'h0}, 32'h0002_0100);
    do_ack(2, 1'b0);

    // Reset mid-request.
    send_frame(8'h01, 8'h02, 8'hAB, 8'hCD, 8'h65, 1'b0);
    check_eq("mid_req", {31'h0, req_out}, 32'd1);
    @(posedge clk_in);
    #3 n_rst = 1'b0;
    #1;
    check_eq("arst_outs", {req_out, busy_out, frame_done, err_cksum, err_cmd, err_timeout,
                           err_overrun}, 32'd0);
    check_eq("arst_fields", {cmd_out, ptr_out, wdata_out}, 32'd0);
    @(negedge clk_in);
    n_rst = 1'b1;
    send(8'h00, 0);
    send(8'hFF, 0);
    check_eq("garbage_idle", {31'h0, busy_out}, 32'd0);
    send_frame(8'h01, 8'h03, 8'h00, 8'h10, 8'h12, 1'b0);
    do_ack(4, 1'b0);

    repeat (5) @(posedge clk_in);
    #1 check_eq("sb_drain", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
- Command-frame controller between the UART receiver and the ADS1115 I2C master.
- Consumes byte pulses from the UART receiver and assembles fixed 6-byte command frames.
- Validates each frame, then issues one register read/write request to the I2C master over a req/ack handshake.
- Reports frame completion and error conditions as single-cycle pulses.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 50000, maximum clk_in cycles allowed between consecutive bytes inside a frame; must be >= 2.
- CMD_WR, 8'h01, command code for register write.
- CMD_RD, 8'h02, command code for register read.

Ports:
- clk_in  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
- rx_valid  input  1  one-cycle pulse, rx_data valid
- rx_data  input  8  received byte
- req_out  output  1  request to I2C master
- cmd_out  output  8  latched command code (CMD_WR/CMD_RD)
- ptr_out  output  8  latched ADS1115 register pointer
- wdata_out  output  16  latched write data {data_hi, data_lo}
- ack_in  input  1  I2C master accepted/completed the request
- busy_out  output  1  high whenever state != S_IDLE
- frame_done  output  1  pulse: request acknowledged
- err_cksum  output  1  pulse: checksum mismatch
- err_cmd  output  1  pulse: unknown command code
- err_timeout  output  1  pulse: inter-byte gap exceeded
- err_overrun  output  1  pulse: byte received while request pending

Behaviour:
- Reset: clk_in, n_rst asynchronous active-low. All outputs 0; state S_IDLE; timeout counter 0; checksum accumulator 0; latched fields 0.
- Frame format: SYNC, CMD, PTR, DHI, DLO, CKS, where CKS = CMD ^ PTR ^ DHI ^ DLO.
- States: S_IDLE, S_CMD, S_PTR, S_DHI, S_DLO, S_CKS, S_ISSUE.
- S_IDLE:
  - rx_valid with rx_data == SYNC_BYTE -> S_CMD; clear accumulator and timeout counter.
  - Any other byte is silently ignored; no error pulse.
- S_CMD..S_DLO: each rx_valid latches the byte into its field, XORs it into the accumulator, clears the timeout counter, and advances one state.
- S_CKS: on rx_valid, checks run in this priority:
  - (accumulator ^ rx_data) != 0 -> err_cksum pulse, go to S_IDLE.
  - Otherwise, cmd not in {CMD_WR, CMD_RD} -> err_cmd pulse, go to S_IDLE.
  - Otherwise -> S_ISSUE.
- Timeout (S_CMD..S_CKS only):
  - Counter increments every cycle without rx_valid.
  - Counter reaching TIMEOUT_CYCLES-1 with no rx_valid that cycle -> err_timeout pulse, go to S_IDLE, clear counter.
  - rx_valid in the same cycle as terminal count: the byte wins; it is accepted and the counter clears.
- S_ISSUE:
  - req_out is registered: asserted on the first cycle in S_ISSUE.
  - req_out stays high, and cmd_out/ptr_out/wdata_out stay stable, until ack_in is sampled high.
  - On that edge: req_out goes 0, frame_done pulses for one cycle, go to S_IDLE.
- Overrun: rx_valid while in S_ISSUE -> err_overrun pulse; byte discarded (not even checked for SYNC); request unaffected.
- Fields: cmd_out/ptr_out/wdata_out hold their last latched values after S_IDLE; a new frame overwrites them as its bytes arrive. Consumers sample them only while req_out = 1.
- ack_in while req_out = 0 is ignored.
- All error and done pulses are registered, exactly one cycle, and mutually exclusive in any cycle.
- Back-to-back: a SYNC byte arriving on the cycle after frame_done (state S_IDLE) starts a new frame.
- Reset asserted mid-frame or mid-request: immediate return to the reset state; req_out drops asynchronously.
- Timeout counter width: $clog2(TIMEOUT_CYCLES); no wrap-around possible.

Test Plan:
- Valid write: A5,01,00,84,83,06 (CKS = 01^00^84^83 = 06) -> req_out=1, cmd=01, ptr=00, wdata=8483. ack_in high 5 cycles later -> req_out=0 and frame_done pulse on the same edge; busy_out=0.
- Checksum error: A5,02,01,00,00,FF -> err_cksum pulse; req_out stays 0; next valid frame is accepted normally.
- Unknown command: A5,07,00,00,00,07 -> err_cmd pulse only (checksum correct); no request.
- Timeout with TIMEOUT_CYCLES=100:
  - A5,01 then no bytes -> err_timeout exactly 99 cycles after the 01 pulse; state S_IDLE.
  - Repeat with the next byte landing on the terminal cycle -> no error; byte accepted.
- Overrun: valid frame issued, ack withheld, then byte 55 sent -> err_overrun pulse; req_out and fields unchanged; subsequent ack -> frame_done.
- Reset mid-request: n_rst low while req_out=1 -> req_out=0 immediately, all outputs 0. After release, garbage bytes 00,FF ignored and a fresh frame completes.
